// File: rtl/rows_writer.sv
// Rows writer: captures a bundle of N_ROWS rows plus a base address, then writes
// the rows to consecutive memory addresses (mod 16), one per accepted memory cycle.
`ifndef N_ROWS
`define N_ROWS 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module rows_writer #(
   parameter int N_ROWS = `N_ROWS,
   parameter int WIDTH  = `WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [N_ROWS-1:0][WIDTH-1:0] in_rows,
   input  logic [3:0]                   base_addr,
   output logic                         in_ready,
   input  logic                         mem_ready,
   output logic                         mem_we,
   output logic [3:0]                   mem_addr,
   output logic [WIDTH-1:0]             mem_wdata,
   output logic                         finish_write
);

   localparam int IDX_W = $clog2(N_ROWS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ROWS - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [3:0]                   base_q, base_d;
   logic [N_ROWS-1:0][WIDTH-1:0] rows_q, rows_d;

   // State register; reset drops any transfer in flight and clears the captured bundle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         rows_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         rows_q  <= rows_d;
      end
   end

   // Next-state logic; outputs are decoded purely from the registered state so no
   // input ever reaches an output combinationally.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      base_d       = base_q;
      rows_d       = rows_q;
      in_ready     = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      finish_write = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               rows_d  = in_rows;
               base_d  = base_addr;
               idx_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = base_q + 4'(idx_q);
            mem_wdata = rows_q[idx_q];
            if (mem_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            finish_write = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rows_writer.sv
// Self-checking bench for rows_writer: each scenario walks a bundle through the
// expected write sequence and compares every cycle against the bench's own model.
module tb_rows_writer;

   localparam int N = 4;
   localparam int W = 8;

   typedef logic [W-1:0] rowArr_t [N];

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic [N-1:0][W-1:0]  in_rows;
   logic [3:0]           base_addr;
   logic                 in_ready;
   logic                 mem_ready;
   logic                 mem_we;
   logic [3:0]           mem_addr;
   logic [W-1:0]         mem_wdata;
   logic                 finish_write;

   int testCount = 0;
   int failCount = 0;

   rows_writer #(.N_ROWS(N), .WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_rows(in_rows),
      .base_addr(base_addr),
      .in_ready(in_ready),
      .mem_ready(mem_ready),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .finish_write(finish_write)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the rising edge, inputs changed right after.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output snapshot packed as {we, addr, data, in_ready, finish}.
   function automatic logic [14:0] observed();
      return {mem_we, mem_addr, mem_wdata, in_ready, finish_write};
   endfunction

   function automatic rowArr_t randomRows();
      rowArr_t r;
      for (int i = 0; i < N; i++) r[i] = W'($urandom);
      return r;
   endfunction

   // Drives one bundle from the IDLE cycle through DONE and back to IDLE. When
   // holdNext is set, the following bundle is held on the inputs throughout so it
   // must be ignored while busy and accepted on the first IDLE edge.
   task automatic runBundle(input string name, input rowArr_t rows, input logic [3:0] base,
                            input int stallAt, input int stallLen, input bit randStall,
                            input bit holdNext, input rowArr_t nextRows, input logic [3:0] nextBase);
      int written = 0;
      int cycles  = 0;
      int stalls  = 0;
      logic [14:0] exp;

      testCount++;
      if (in_ready !== 1'b1) begin
         $display("[TB] FAIL %s ready_before_accept: got in_ready=%b expected 1", name, in_ready);
         failCount++;
      end

      in_valid  = 1'b1;
      for (int i = 0; i < N; i++) in_rows[i] = rows[i];
      base_addr = base;
      mem_ready = 1'b1;
      tick();

      while (written < N) begin
         if (holdNext) begin
            in_valid  = 1'b1;
            for (int i = 0; i < N; i++) in_rows[i] = nextRows[i];
            base_addr = nextBase;
         end else begin
            in_valid  = 1'($urandom_range(0, 1));
            in_rows   = {N{W'($urandom)}};
            base_addr = 4'($urandom);
         end

         exp = {1'b1, 4'(int'(base) + written), rows[written], 1'b0, 1'b0};
         testCount++;
         if (observed() !== exp) begin
            $display("[TB] FAIL %s row%0d cycle%0d: got {we,addr,data,rdy,fin}=%h required %h",
                     name, written, cycles, observed(), exp);
            failCount++;
         end

         if (cycles >= 40)                                   mem_ready = 1'b1;
         else if (randStall)                                 mem_ready = 1'($urandom_range(0, 1));
         else if (written == stallAt && stalls < stallLen)   mem_ready = 1'b0;
         else                                                mem_ready = 1'b1;
         if (!mem_ready) stalls++;

         tick();
         if (mem_ready) written++;
         cycles++;
      end

      mem_ready = 1'($urandom_range(0, 1));
      exp = {1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
      testCount++;
      if (observed() !== exp) begin
         $display("[TB] FAIL %s done_cycle: got {we,addr,data,rdy,fin}=%h required %h",
                  name, observed(), exp);
         failCount++;
      end

      in_valid = holdNext;
      tick();
      exp = {1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
      testCount++;
      if (observed() !== exp) begin
         $display("[TB] FAIL %s back_to_idle: got {we,addr,data,rdy,fin}=%h required %h",
                  name, observed(), exp);
         failCount++;
      end
   endtask

   task automatic test_reset();
      logic [14:0] exp = {1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_rows   = {N{W'($urandom)}};
      base_addr = 4'($urandom);
      mem_ready = 1'b1;
      tick();
      tick();
      testCount++;
      if (observed() !== exp) begin
         $display("[TB] FAIL reset_state: got {we,addr,data,rdy,fin}=%h required %h", observed(), exp);
         failCount++;
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      testCount++;
      if (observed() !== exp) begin
         $display("[TB] FAIL after_reset_idle: got {we,addr,data,rdy,fin}=%h required %h", observed(), exp);
         failCount++;
      end
   endtask

   task automatic test_basic();
      rowArr_t r = '{8'h11, 8'h22, 8'h33, 8'h44};
      runBundle("basic", r, 4'd2, -1, 0, 1'b0, 1'b0, r, 4'd0);
   endtask

   task automatic test_backpressure();
      rowArr_t r = '{8'h11, 8'h22, 8'h33, 8'h44};
      runBundle("backpressure", r, 4'd2, 1, 3, 1'b0, 1'b0, r, 4'd0);
   endtask

   task automatic test_wrap();
      rowArr_t r = randomRows();
      runBundle("wrap", r, 4'd14, -1, 0, 1'b0, 1'b0, r, 4'd0);
   endtask

   task automatic test_busy();
      rowArr_t a = '{8'h11, 8'h22, 8'h33, 8'h44};
      rowArr_t b = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
      runBundle("busy_first", a, 4'd7, 2, 2, 1'b0, 1'b1, b, 4'd9);
      runBundle("busy_second", b, 4'd9, -1, 0, 1'b0, 1'b0, b, 4'd0);
   endtask

   task automatic test_reset_mid();
      rowArr_t r = randomRows();
      rowArr_t n = randomRows();
      logic [3:0] b = 4'($urandom);
      logic [14:0] exp;

      in_valid  = 1'b1;
      for (int i = 0; i < N; i++) in_rows[i] = r[i];
      base_addr = b;
      mem_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      exp = {1'b1, b, r[0], 1'b0, 1'b0};
      testCount++;
      if (observed() !== exp) begin
         $display("[TB] FAIL reset_mid first_write: got %h required %h", observed(), exp);
         failCount++;
      end
      tick();
      exp = {1'b1, 4'(b + 4'd1), r[1], 1'b0, 1'b0};
      testCount++;
      if (observed() !== exp) begin
         $display("[TB] FAIL reset_mid second_write: got %h required %h", observed(), exp);
         failCount++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp = {1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
      for (int c = 0; c < 4; c++) begin
         testCount++;
         if (observed() !== exp) begin
            $display("[TB] FAIL reset_mid aborted cycle%0d: got %h required %h", c, observed(), exp);
            failCount++;
         end
         tick();
      end
      runBundle("after_reset", n, 4'($urandom), -1, 0, 1'b0, 1'b0, n, 4'd0);
   endtask

   task automatic test_back_to_back();
      rowArr_t bundles [3];
      logic [3:0] bases [3];
      for (int i = 0; i < 3; i++) begin
         bundles[i] = randomRows();
         bases[i]   = 4'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
         runBundle("back_to_back", bundles[i], bases[i], -1, 0, 1'b0, (i < 2),
                   bundles[(i + 1) % 3], bases[(i + 1) % 3]);
      end
   endtask

   task automatic test_random();
      rowArr_t bundles [6];
      logic [3:0] bases [6];
      for (int i = 0; i < 6; i++) begin
         bundles[i] = randomRows();
         bases[i]   = 4'($urandom);
      end
      for (int i = 0; i < 6; i++) begin
         runBundle("random", bundles[i], bases[i], -1, 0, 1'b1, (i % 2 == 0),
                   bundles[(i + 1) % 6], bases[(i + 1) % 6]);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_rows   = '0;
      base_addr = '0;
      mem_ready = 1'b0;

      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
